// File: rtl/ext_uart.sv
// ext_uart: 8N1 UART on the external 8-bit register bus.
// Optional receiver is built only when EXT_UART_RX_EN is defined; the default build is TX only.
// Ports: clk/reset (async, active-high), ext_adr/ext_do/ext_oe write bus, ext_di registered read data,
//        uart_txd serial out (idles high), uart_rxd serial in (asynchronous).
// Registers (ext_adr[1:0]): 0 DATA, 1 STAT, 2 DIVL, 3 DIVH. Read latency one cycle, no read side effects.
module ext_uart #(
    parameter int DEFAULT_DIV = 433,
    parameter int FIFO_AW     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] ext_adr,
    input  logic [7:0] ext_do,
    input  logic       ext_oe,
    output logic [7:0] ext_di,
    output logic       uart_txd,
    input  logic       uart_rxd
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    logic [15:0] r_div;
    logic [15:0] w_div_eff;
    logic [7:0]  r_di;
    logic [7:0]  w_rd_dat;
    logic        w_wr_data, w_wr_stat, w_unused;
    logic [7:0]  w_rx_head;
    logic        w_rx_valid, w_ovr, w_ferr;

    assign w_wr_data = ext_oe && (ext_adr[1:0] == 2'd0);
    assign w_wr_stat = ext_oe && (ext_adr[1:0] == 2'd1);
    // Divisors below 3 leave too few clocks per bit for mid-bit sampling.
    assign w_div_eff = (r_div < 16'd3) ? 16'd3 : r_div;

    // ---------------- TX FIFO + transmitter ----------------
    logic [7:0]       r_tx_mem [DEPTH];
    logic [FIFO_AW:0] r_tx_wp, r_tx_rp;
    logic             w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_tx_tick;
    uart_state_t      r_tx_st, w_tx_st_nxt;
    logic [15:0]      r_tx_cnt, r_tx_div;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_sh;
    logic             r_txd;

    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[FIFO_AW] != r_tx_rp[FIFO_AW]) &&
                        (r_tx_wp[FIFO_AW-1:0] == r_tx_rp[FIFO_AW-1:0]);
    assign w_tx_push  = w_wr_data && !w_tx_full;
    assign w_tx_tick  = (r_tx_cnt == r_tx_div);

    always_comb begin
        w_tx_st_nxt = r_tx_st;
        w_tx_pop    = 1'b0;
        case (r_tx_st)
            ST_IDLE:  if (!w_tx_empty) begin w_tx_pop = 1'b1; w_tx_st_nxt = ST_START; end
            ST_START: if (w_tx_tick) w_tx_st_nxt = ST_DATA;
            ST_DATA:  if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_st_nxt = ST_STOP;
            ST_STOP:  if (w_tx_tick) begin
                          // Back-to-back frames skip IDLE when more data is queued.
                          if (!w_tx_empty) begin w_tx_pop = 1'b1; w_tx_st_nxt = ST_START; end
                          else w_tx_st_nxt = ST_IDLE;
                      end
            default:  w_tx_st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[FIFO_AW-1:0]] <= ext_do;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_wp <= '0; r_tx_rp <= '0; r_tx_st <= ST_IDLE;
            r_tx_cnt <= '0; r_tx_div <= '0; r_tx_bit <= '0; r_tx_sh <= '0;
            r_txd <= 1'b1;
        end else begin
            r_tx_st <= w_tx_st_nxt;
            if (w_tx_push) r_tx_wp <= r_tx_wp + PTR_ONE;
            if (w_tx_pop) begin
                r_tx_rp  <= r_tx_rp + PTR_ONE;
                r_tx_sh  <= r_tx_mem[r_tx_rp[FIFO_AW-1:0]];
                r_tx_div <= w_div_eff;
                r_tx_cnt <= '0;
                r_tx_bit <= '0;
            end else if (r_tx_st != ST_IDLE) begin
                if (w_tx_tick) begin
                    r_tx_cnt <= '0;
                    if (r_tx_st == ST_DATA) begin
                        r_tx_sh  <= r_tx_sh >> 1;
                        r_tx_bit <= r_tx_bit + 3'd1;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + 16'd1;
                end
            end
            // Line level is registered from state, so it lags the FSM by one clock.
            r_txd <= (r_tx_st == ST_START) ? 1'b0 : (r_tx_st == ST_DATA) ? r_tx_sh[0] : 1'b1;
        end
    end

`ifdef EXT_UART_RX_EN
    // ---------------- receiver + RX FIFO ----------------
    logic             r_rx_s1, r_rx_s2, r_rx_prev;
    uart_state_t      r_rx_st, w_rx_st_nxt;
    logic [15:0]      r_rx_cnt, r_rx_div, w_rx_half;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_sh;
    logic [7:0]       r_rx_mem [DEPTH];
    logic [FIFO_AW:0] r_rx_wp, r_rx_rp;
    logic             r_ovr, r_ferr;
    logic             w_rx_empty, w_rx_full, w_rx_pop, w_rx_push, w_rx_stop, w_rx_tick;

    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[FIFO_AW] != r_rx_rp[FIFO_AW]) &&
                        (r_rx_wp[FIFO_AW-1:0] == r_rx_rp[FIFO_AW-1:0]);
    assign w_rx_pop   = w_wr_stat && ext_do[0] && !w_rx_empty;
    // START counts from the clock after the falling edge was seen, hence the -1.
    assign w_rx_half  = {1'b0, r_rx_div[15:1]} + {15'd0, r_rx_div[0]} - 16'd1;
    assign w_rx_tick  = (r_rx_st == ST_START) ? (r_rx_cnt == w_rx_half) : (r_rx_cnt == r_rx_div);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign w_rx_push  = w_rx_stop && r_rx_s2 && (!w_rx_full || w_rx_pop);

    always_comb begin
        w_rx_st_nxt = r_rx_st;
        w_rx_stop   = 1'b0;
        case (r_rx_st)
            ST_IDLE:  if (r_rx_prev && !r_rx_s2) w_rx_st_nxt = ST_START;
            ST_START: if (w_rx_tick) w_rx_st_nxt = r_rx_s2 ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_st_nxt = ST_STOP;
            ST_STOP:  if (w_rx_tick) begin w_rx_stop = 1'b1; w_rx_st_nxt = ST_IDLE; end
            default:  w_rx_st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp[FIFO_AW-1:0]] <= r_rx_sh;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_prev <= 1'b1;
            r_rx_st <= ST_IDLE; r_rx_cnt <= '0; r_rx_div <= '0; r_rx_bit <= '0; r_rx_sh <= '0;
            r_rx_wp <= '0; r_rx_rp <= '0; r_ovr <= 1'b0; r_ferr <= 1'b0;
        end else begin
            r_rx_s1   <= uart_rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_rx_st   <= w_rx_st_nxt;
            if (r_rx_st == ST_IDLE) begin
                r_rx_cnt <= '0;
                r_rx_bit <= '0;
                r_rx_div <= w_div_eff;
            end else if (w_rx_tick) begin
                r_rx_cnt <= '0;
                if (r_rx_st == ST_DATA) begin
                    r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                    r_rx_bit <= r_rx_bit + 3'd1;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt + 16'd1;
            end
            if (w_rx_push) r_rx_wp <= r_rx_wp + PTR_ONE;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + PTR_ONE;
            // A set in the same cycle as a clear wins so no event is lost.
            if (w_rx_stop && r_rx_s2 && !w_rx_push) r_ovr <= 1'b1;
            else if (w_wr_stat && ext_do[4])        r_ovr <= 1'b0;
            if (w_rx_stop && !r_rx_s2)              r_ferr <= 1'b1;
            else if (w_wr_stat && ext_do[5])        r_ferr <= 1'b0;
        end
    end

    assign w_rx_valid = !w_rx_empty;
    assign w_rx_head  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[FIFO_AW-1:0]];
    assign w_ovr      = r_ovr;
    assign w_ferr     = r_ferr;
    assign w_unused   = ^ext_adr[9:2];
`else
    assign w_rx_valid = 1'b0;
    assign w_rx_head  = 8'h00;
    assign w_ovr      = 1'b0;
    assign w_ferr     = 1'b0;
    assign w_unused   = ^{ext_adr[9:2], uart_rxd, w_wr_stat};
`endif

    // ---------------- register file ----------------
    always_comb begin
        w_rd_dat = 8'h00;
        case (ext_adr[1:0])
            2'd0: w_rd_dat = w_rx_head;
            2'd1: w_rd_dat = {2'b00, w_ferr, w_ovr, (r_tx_st != ST_IDLE), w_tx_empty, w_tx_full, w_rx_valid};
            2'd2: w_rd_dat = r_div[7:0];
            2'd3: w_rd_dat = r_div[15:8];
            default: w_rd_dat = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= 16'(DEFAULT_DIV);
            r_di  <= 8'h00;
        end else begin
            r_di <= w_rd_dat;
            if (ext_oe && (ext_adr[1:0] == 2'd2)) r_div[7:0]  <= ext_do;
            if (ext_oe && (ext_adr[1:0] == 2'd3)) r_div[15:8] <= ext_do;
        end
    end

    assign ext_di   = r_di;
    assign uart_txd = r_txd;
endmodule

// File: tb/tb_ext_uart.sv
module tb_ext_uart;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] ext_adr = '0;
    logic [7:0] ext_do = '0;
    logic       ext_oe = 1'b0;
    logic [7:0] ext_di;
    logic       uart_txd;
    logic       uart_rxd = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [7:0] rd;
    logic [9:0] fr;
    logic [8:0] expq;
    logic       mon_en = 1'b0;
    logic [8:0] mon_q[$];

    ext_uart dut (
        .clk(clk), .reset(reset), .ext_adr(ext_adr), .ext_do(ext_do), .ext_oe(ext_oe),
        .ext_di(ext_di), .uart_txd(uart_txd), .uart_rxd(uart_rxd)
    );

    always #5 clk = ~clk;

    // Serial decoder for the TX line, 4 clocks per bit; samples the second clock of each bit.
    always begin
        logic [8:0] f;
        @(negedge clk);
        if (mon_en && (uart_txd == 1'b0)) begin
            @(negedge clk);
            for (int b = 0; b < 9; b++) begin
                repeat (4) @(negedge clk);
                f[b] = uart_txd;
            end
            mon_q.push_back(f);
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        ext_adr = {8'h00, a}; ext_do = d; ext_oe = 1'b1;
        @(negedge clk);
        ext_oe = 1'b0;
    endtask

    task automatic rdreg(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        ext_adr = {8'h00, a};
        @(negedge clk);
        d = ext_di;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stp);
        logic [9:0] f;
        f = {stp, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rxd = f[k];
            repeat (4) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ext_di", {8'h00, ext_di}, 16'h0000);
        chk("rst_txd", {15'h0, uart_txd}, 16'h0001);
        reset = 1'b0;
        rdreg(2'd1, rd); chk("rst_stat", {8'h00, rd}, 16'h0004);
        rdreg(2'd2, rd); chk("rst_divl", {8'h00, rd}, 16'h00B1);
        rdreg(2'd3, rd); chk("rst_divh", {8'h00, rd}, 16'h0001);

        // Divisor 3 -> 4 clocks per bit
        wr(2'd2, 8'h03);
        wr(2'd3, 8'h00);
        rdreg(2'd2, rd); chk("divl_wr", {8'h00, rd}, 16'h0003);
        rdreg(2'd3, rd); chk("divh_wr", {8'h00, rd}, 16'h0000);

        // Single frame 0xA5: start appears two clocks after the write edge
        wr(2'd0, 8'hA5);
        chk("tx_lat0", {15'h0, uart_txd}, 16'h0001);
        @(negedge clk);
        chk("tx_lat1", {15'h0, uart_txd}, 16'h0001);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk($sformatf("tx_a5_clk%0d", k), {15'h0, uart_txd}, {15'h0, fr[k/4]});
        end
        rdreg(2'd1, rd); chk("tx_done_stat", {8'h00, rd}, 16'h0004);

        // 17 back-to-back writes: first pop happens one clock after write 1, so all 17 fit
        mon_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            ext_adr = 10'd0; ext_do = 8'h10 + 8'(i); ext_oe = 1'b1;
            @(negedge clk);
        end
        ext_oe = 1'b0;
        rdreg(2'd1, rd); chk("tx_full_stat", {8'h00, rd}, 16'h000A);
        repeat (720) @(negedge clk);
        chk("tx_frames", 16'(mon_q.size()), 16'd17);
        for (int i = 0; i < 17; i++) begin
            expq = {1'b1, 8'h10 + 8'(i)};
            if (i < mon_q.size()) chk($sformatf("tx_byte%0d", i), {7'h0, mon_q[i]}, {7'h0, expq});
        end
        rdreg(2'd1, rd); chk("tx_drain_stat", {8'h00, rd}, 16'h0004);

        // Divisor 0 is clamped to 3, so the 4-clock decoder still reads the frame
        wr(2'd2, 8'h00);
        wr(2'd0, 8'h5A);
        repeat (60) @(negedge clk);
        chk("clamp_frames", 16'(mon_q.size()), 16'd18);
        expq = {1'b1, 8'h5A};
        if (mon_q.size() > 17) chk("clamp_byte", {7'h0, mon_q[17]}, {7'h0, expq});
        mon_en = 1'b0;

`ifdef EXT_UART_RX_EN
        rx_send(8'h3C, 1'b1);
        rdreg(2'd1, rd); chk("rx_stat_valid", {8'h00, rd}, 16'h0005);
        rdreg(2'd0, rd); chk("rx_data_3c", {8'h00, rd}, 16'h003C);
        wr(2'd1, 8'h01);
        rdreg(2'd0, rd); chk("rx_data_popped", {8'h00, rd}, 16'h0000);
        rdreg(2'd1, rd); chk("rx_stat_popped", {8'h00, rd}, 16'h0004);
        for (int i = 0; i < 17; i++) rx_send(8'h40 + 8'(i), 1'b1);
        rdreg(2'd1, rd); chk("rx_overrun_stat", {8'h00, rd}, 16'h0015);
        for (int i = 0; i < 16; i++) begin
            rdreg(2'd0, rd); chk($sformatf("rx_byte%0d", i), {8'h00, rd}, {8'h00, 8'h40 + 8'(i)});
            wr(2'd1, 8'h01);
        end
        rdreg(2'd1, rd); chk("rx_empty_ovr", {8'h00, rd}, 16'h0014);
        @(negedge clk); uart_rxd = 1'b0;
        repeat (2) @(negedge clk); uart_rxd = 1'b1;
        repeat (50) @(negedge clk);
        rdreg(2'd1, rd); chk("rx_glitch", {8'h00, rd}, 16'h0014);
        rx_send(8'h55, 1'b0);
        rdreg(2'd1, rd); chk("rx_frame_err", {8'h00, rd}, 16'h0034);
        rdreg(2'd0, rd); chk("rx_ferr_nodata", {8'h00, rd}, 16'h0000);
        wr(2'd1, 8'h30);
        rdreg(2'd1, rd); chk("rx_sticky_clr", {8'h00, rd}, 16'h0004);
`else
        rx_send(8'h3C, 1'b1);
        rdreg(2'd0, rd); chk("norx_data", {8'h00, rd}, 16'h0000);
        rdreg(2'd1, rd); chk("norx_stat", {8'h00, rd}, 16'h0004);
        wr(2'd1, 8'h31);
        rdreg(2'd1, rd); chk("norx_stat_wr", {8'h00, rd}, 16'h0004);
`endif

        // Reset mid-frame forces the line high without a clock edge
        wr(2'd0, 8'h77);
        repeat (3) @(negedge clk);
        chk("mid_start_low", {15'h0, uart_txd}, 16'h0000);
        #2 reset = 1'b1;
        #1 chk("mid_rst_txd", {15'h0, uart_txd}, 16'h0001);
        @(negedge clk);
        reset = 1'b0;
        rdreg(2'd1, rd); chk("mid_rst_stat", {8'h00, rd}, 16'h0004);
        rdreg(2'd2, rd); chk("mid_rst_divl", {8'h00, rd}, 16'h00B1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
